// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its
// prefetch FIFO.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Entry layout: {pc[63:32], instr[31:0]}
    localparam int ENTRY_W           = 64;
    localparam int DEFAULT_DEPTH     = 4;
    localparam int DEFAULT_MEM_WORDS = 32;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with first-word fall-through head, synchronous flush and
// occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign pop_ok  = pop_i & (cnt_q != '0);
    assign push_ok = push_i & ((cnt_q != FULL_CNT) | pop_ok);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (cnt_q != '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches from instruction memory into the
// prefetch FIFO, and handles redirects and the end-of-memory halt.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter int          MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    output logic [31:0]            imem_addr_o,
    input  logic [31:0]            imem_instr_i,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output logic [31:0]            dec_instr_o,
    output logic [31:0]            dec_pc_o,
    output logic [$clog2(DEPTH):0] fifo_cnt_o,
    output logic                   halted_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [31:0]      MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [31:0]      LAST_PC   = 32'((MEM_WORDS - 1) * 4);

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic [31:0]          pc_q;
    logic [31:0]          pc_d;
    logic [31:0]          target_pc;
    logic                 flush;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   head;
    logic [CNT_W-1:0]     cnt;
    logic                 head_valid;

    assign target_pc = align_word(redirect_pc_i);
    assign pop       = head_valid & dec_ready_i;
    assign flush     = redirect_i & (state_q != IDLE);
    assign push      = (state_q == FETCH) & ~redirect_i & ((cnt != FULL_CNT) | pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Redirect outranks both the normal push and the end-of-memory halt.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                end
            end
            FETCH, HALT: begin
                if (redirect_i) begin
                    pc_d    = target_pc;
                    state_d = (target_pc >= MEM_BYTES) ? HALT : FETCH;
                end else if (push) begin
                    pc_d = pc_q + 32'd4;
                    if (pc_q == LAST_PC) begin
                        state_d = HALT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pc_q, imem_instr_i}),
        .rdata_o (head),
        .valid_o (head_valid),
        .cnt_o   (cnt)
    );

    assign imem_addr_o = pc_q;
    assign dec_valid_o = head_valid;
    assign dec_pc_o    = head[63:32];
    assign dec_instr_o = head[31:0];
    assign fifo_cnt_o  = cnt;
    assign halted_o    = (state_q == HALT) & (cnt == '0);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed phases push expected
// decode entries, a negedge monitor checks every accepted handshake.
module tb_instr_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic [2:0]  fifo_cnt_o;
    logic        halted_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    instr_fetch_ctrl #(
        .DEPTH     (4),
        .MEM_WORDS (32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .fifo_cnt_o    (fifo_cnt_o),
        .halted_o      (halted_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory model: word k holds 0x1000_0000 + k.
    assign imem_instr_i = 32'h1000_0000 + {2'b00, imem_addr_o[31:2]};

    function automatic logic [31:0] memWord(input logic [31:0] pc);
        return 32'h1000_0000 + {2'b00, pc[31:2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic redirect,
                                 input logic [31:0] rpc, input logic ready);
        start_i       = start;
        redirect_i    = redirect;
        redirect_pc_i = rpc;
        dec_ready_i   = ready;
    endtask

    task automatic expectEntry(input logic [31:0] pc);
        exp_q.push_back({pc, memWord(pc)});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkReset();
        checkOutput("rst_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("rst_instr", dec_instr_o, 32'd0);
        checkOutput("rst_pc", dec_pc_o, 32'd0);
        checkOutput("rst_cnt", 32'(fifo_cnt_o), 32'd0);
        checkOutput("rst_halted", 32'(halted_o), 32'd0);
        checkOutput("rst_addr", imem_addr_o, 32'd0);
    endtask

    // Scoreboard monitor: every accepted head must match the next expectation.
    always @(negedge clk_i) begin
        if (rst_i && dec_valid_o && dec_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got pc 0x%08h instr 0x%08h, expected no entry",
                         dec_pc_o, dec_instr_o);
            end else begin
                logic [63:0] exp_e;
                exp_e = exp_q.pop_front();
                if ({dec_pc_o, dec_instr_o} !== exp_e) begin
                    errors++;
                    $display("[TB] FAIL sb_entry: got pc 0x%08h instr 0x%08h, expected pc 0x%08h instr 0x%08h",
                             dec_pc_o, dec_instr_o, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        #1 rst_i = 1'b0;
        #1 checkReset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Streaming with decode always ready.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 4; k++) expectEntry(32'(k * 4));
        step();
        checkOutput("start_valid0", 32'(dec_valid_o), 32'd0);
        checkOutput("start_addr0", imem_addr_o, 32'd0);
        step();
        checkOutput("first_valid", 32'(dec_valid_o), 32'd1);
        checkOutput("first_cnt", 32'(fifo_cnt_o), 32'd1);
        checkOutput("first_addr", imem_addr_o, 32'd4);
        repeat (4) step();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("stream_head", dec_pc_o, 32'd16);

        // Stall until three entries are held, then redirect to an unaligned target.
        repeat (2) step();
        checkOutput("pre_redir_cnt", 32'(fifo_cnt_o), 32'd3);
        applyStimulus(1'b1, 1'b1, 32'h0000_0033, 1'b0);
        step();
        checkOutput("redir_cnt", 32'(fifo_cnt_o), 32'd0);
        checkOutput("redir_addr", imem_addr_o, 32'h30);
        checkOutput("redir_valid", 32'(dec_valid_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("redir_head_pc", dec_pc_o, 32'h30);
        checkOutput("redir_head_instr", dec_instr_o, 32'h1000_000C);

        // Asynchronous reset between clock edges.
        #2 rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        #1 checkReset();
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Fill with decode stalled: count saturates and the PC freezes.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("refetch_addr", imem_addr_o, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            int n;
            n = (k < 4) ? k : 4;
            step();
            checkOutput("fill_cnt", 32'(fifo_cnt_o), 32'(n));
            checkOutput("fill_addr", imem_addr_o, 32'(n * 4));
        end
        checkOutput("fill_head", dec_pc_o, 32'd0);

        // Full FIFO with one cycle of ready: simultaneous push and pop.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        expectEntry(32'd0);
        step();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("fullpop_cnt", 32'(fifo_cnt_o), 32'd4);
        checkOutput("fullpop_addr", imem_addr_o, 32'd20);

        // Drain to the end of memory.
        for (int k = 1; k < 32; k++) expectEntry(32'(k * 4));
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            step();
            if (halted_o) break;
        end
        checkOutput("end_halted", 32'(halted_o), 32'd1);
        checkOutput("end_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("end_addr", imem_addr_o, 32'd128);
        step();
        checkOutput("end_hold_cnt", 32'(fifo_cnt_o), 32'd0);
        checkOutput("end_hold_addr", imem_addr_o, 32'd128);

        // Redirect out of HALT back into memory.
        applyStimulus(1'b0, 1'b1, 32'd8, 1'b0);
        step();
        checkOutput("restart_halted", 32'(halted_o), 32'd0);
        checkOutput("restart_addr", imem_addr_o, 32'd8);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("restart_cnt", 32'(fifo_cnt_o), 32'd1);
        checkOutput("restart_head_pc", dec_pc_o, 32'd8);
        checkOutput("restart_head_instr", dec_instr_o, 32'h1000_0002);

        // Out-of-range redirect halts with an empty FIFO; start is then ignored.
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        step();
        checkOutput("oor_halted", 32'(halted_o), 32'd1);
        checkOutput("oor_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("oor_addr", imem_addr_o, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("oor_start_ignored", 32'(halted_o), 32'd1);
        checkOutput("oor_hold_addr", imem_addr_o, 32'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the 32-word instruction memory.
- Owns the PC and drives the memory's word address.
- Captures each returned instruction with its PC into a small prefetch FIFO.
- Hands entries to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush and reload) and stops fetching at the end of memory.
- Sits between Instr_Memory and the decode/control stage of the single-cycle/pipelined CPU.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MEM_WORDS, 32, instruction memory size in words; last fetchable PC = (MEM_WORDS-1)*4
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk_i  input  1  single clock; all state changes on its rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  leave IDLE and begin fetching (level, sampled each cycle)
redirect_i  input  1  branch/jump taken: flush FIFO, reload PC
redirect_pc_i  input  32  new PC for redirect
imem_addr_o  output  32  byte address to Instr_Memory pc_addr_i (= PC register)
imem_instr_i  input  32  instruction from Instr_Memory; combinational, valid the same cycle
dec_valid_o  output  1  FIFO head valid
dec_ready_i  input  1  decode accepts head
dec_instr_o  output  32  head instruction
dec_pc_o  output  32  head PC
fifo_cnt_o  output  $clog2(DEPTH)+1  current occupancy
halted_o  output  1  fetch stopped at end of memory and FIFO drained

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE, PC=RESET_PC, FIFO empty (cnt=0, pointers 0), stored entries cleared.
  - Outputs: dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, fifo_cnt_o=0, halted_o=0, imem_addr_o=RESET_PC.
  - Mid-operation reset discards everything immediately.
- States:
  - IDLE: no fetch. start_i=1 -> FETCH. redirect_i is ignored in IDLE.
  - FETCH: push when allowed (below). A push at PC=(MEM_WORDS-1)*4 -> HALT on the same edge.
  - HALT: no fetch; start_i ignored. redirect_i -> FETCH, or stays HALT if the target is out of range.
- imem_addr_o = PC register (combinational from the flop).
- pop = dec_valid_o & dec_ready_i. Pop advances the read pointer.
- dec_valid_o = (cnt != 0). dec_instr_o and dec_pc_o show the head entry (first-word fall-through, from registers). Values are don't-care when dec_valid_o=0, except after reset.
- push = (state==FETCH) & ~redirect_i & ((cnt<DEPTH) | pop).
  - Push writes {PC, imem_instr_i} at the write pointer and sets PC <= PC+4 (32-bit wrap is never reached because of HALT).
- Full FIFO + pop in the same cycle: push still allowed, cnt unchanged.
- Empty FIFO: a push in the cycle that fills it produces no same-cycle bypass. The entry is visible the next cycle (1-cycle fetch-to-decode latency).
- cnt update: +1 push only, -1 pop only, unchanged on both or neither.
- Redirect (state FETCH or HALT):
  - Flush: cnt=0, pointers=0.
  - PC <= {redirect_pc_i[31:2],2'b00} (force word alignment).
  - No push that cycle. A simultaneous pop counts as consumed but is irrelevant after the flush.
  - If the aligned target >= MEM_WORDS*4: state=HALT with an empty FIFO, so halted_o=1 the next cycle. Otherwise state=FETCH.
- Redirect has priority over push and over the HALT transition.
- halted_o = (state==HALT) & (cnt==0), registered-path combinational from the flops.
- Addresses are byte addresses; the memory word index is PC>>2. PC bits [1:0] are always 0.

Decomposition:
- Shared package fetch_pkg:
  - state localparams IDLE=2'd0, FETCH=2'd1, HALT=2'd2
  - ENTRY_W=64 (entry layout {pc[63:32], instr[31:0]})
  - default DEPTH/MEM_WORDS constants.
- One sub-module: fetch_fifo, a synchronous FIFO with a flush input, push/pop, count, and fall-through head. Same clk_i/rst_i.
- The PC/state logic stays in instr_fetch_ctrl.

Test Plan:
- Reset then start_i=1 with dec_ready_i=1 held, memory word k = 32'h1000_0000+k:
  - dec_valid_o first rises 1 cycle after start.
  - Then one entry per cycle: pc 0,4,8,... with matching instr.
- dec_ready_i=0 after start:
  - fifo_cnt_o climbs 1..4 and stays at 4; imem_addr_o freezes at 16.
  - Raising dec_ready_i delivers pcs 0,4,8,12 in order, with no loss or duplication.
- FIFO full, dec_ready_i=1 for one cycle: fifo_cnt_o stays 4 and PC advances 16->20 (simultaneous push+pop).
- Redirect_i with redirect_pc_i=32'h0000_0033 while the FIFO holds 3 entries:
  - Next cycle fifo_cnt_o=0 and imem_addr_o=32'h30.
  - The following cycle dec_pc_o=32'h30.
- Run to the end with dec_ready_i=1:
  - The last entry has pc=124. No further push.
  - halted_o=1 once the FIFO empties.
  - A subsequent redirect to 8 restarts fetch from pc 8 with halted_o=0.
- Redirect to 32'h200 (out of range): halted_o=1 next cycle, dec_valid_o=0.
- Separately, assert rst_i=0 mid-run (between clock edges): all outputs are at reset values immediately (asynchronous), and after release a new start_i refetches from pc 0.
